// File: rtl/demux_pkg.sv
// Shared widths and buffer state encoding for the demux_reg block.
package demux_pkg;

  localparam int unsigned DEMUX_WIDTH = 32;
  localparam int unsigned DEMUX_CNT_W = 16;

  // Encoded so that bit 0 is "holds a word" and bit 1 is "full".
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b11
  } buf_state_t;

endpackage

// File: rtl/demux_if.sv
// Input and dual-output valid/ready bundle for demux_reg.
// master: producer/consumer side; slave: the demux itself.
interface demux_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;

  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;

  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;

  modport master (
    output in_valid, in_data, in_sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data
  );

endinterface

// File: rtl/demux_buf.sv
// Two-entry output buffer: EMPTY/ONE/FULL state machine, registered head
// word and valid. Optional saturating pop counter under DEMUX_STATS_EN.
module demux_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
`ifdef DEMUX_STATS_EN
  ,
  output logic [DEMUX_CNT_W-1:0] cnt_o
`endif
);

  localparam logic [1:0] ST_EMPTY = BUF_EMPTY;
  localparam logic [1:0] ST_ONE   = BUF_ONE;
  localparam logic [1:0] ST_FULL  = BUF_FULL;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop;

  assign pop     = (state_q != ST_EMPTY) && ready_i;
  assign valid_o = (state_q != ST_EMPTY);
  assign full_o  = (state_q == ST_FULL);
  assign data_o  = head_q;

  // State and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next state; a push into ONE with a same-cycle pop replaces the head.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_i) begin
          state_d = ST_ONE;
          head_d  = data_i;
        end
      end
      ST_ONE: begin
        if (push_i && pop) begin
          head_d = data_i;
        end else if (push_i) begin
          state_d = ST_FULL;
          tail_d  = data_i;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

`ifdef DEMUX_STATS_EN
  logic [DEMUX_CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_o = cnt_q;

  // Saturating delivered-word counter.
  always_comb begin
    cnt_d = cnt_q;
    if (pop && (cnt_q != {DEMUX_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + DEMUX_CNT_W'(1);
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: rtl/demux_reg.sv
// Registered 1-to-2 demultiplexer: in_sel=1 routes to A, 0 routes to B.
// Optional per-channel delivered-word counters under DEMUX_STATS_EN.
module demux_reg
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  demux_if.slave bus
`ifdef DEMUX_STATS_EN
  ,
  output logic [DEMUX_CNT_W-1:0] cnt_a,
  output logic [DEMUX_CNT_W-1:0] cnt_b
`endif
);

  logic a_full;
  logic b_full;
  logic push_a;
  logic push_b;

  // Ready follows only the selected buffer; held low while in reset.
  assign bus.in_ready = rst_n & ~(bus.in_sel ? a_full : b_full);
  assign push_a       = bus.in_valid & bus.in_ready & bus.in_sel;
  assign push_b       = bus.in_valid & bus.in_ready & ~bus.in_sel;

  demux_buf #(.WIDTH(WIDTH)) u_buf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_a),
    .data_i  (bus.in_data),
    .ready_i (bus.a_ready),
    .valid_o (bus.a_valid),
    .full_o  (a_full),
    .data_o  (bus.a_data)
`ifdef DEMUX_STATS_EN
    ,
    .cnt_o   (cnt_a)
`endif
  );

  demux_buf #(.WIDTH(WIDTH)) u_buf_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_b),
    .data_i  (bus.in_data),
    .ready_i (bus.b_ready),
    .valid_o (bus.b_valid),
    .full_o  (b_full),
    .data_o  (bus.b_data)
`ifdef DEMUX_STATS_EN
    ,
    .cnt_o   (cnt_b)
`endif
  );

endmodule

// File: tb/tb_demux_reg.sv
// Directed bench for demux_reg; counter checks only with DEMUX_STATS_EN.
module tb_demux_reg;
  import demux_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  demux_if #(.WIDTH(DEMUX_WIDTH)) bus ();

`ifdef DEMUX_STATS_EN
  logic [DEMUX_CNT_W-1:0] cnt_a;
  logic [DEMUX_CNT_W-1:0] cnt_b;
`endif

  demux_reg #(.WIDTH(DEMUX_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef DEMUX_STATS_EN
    ,
    .cnt_a (cnt_a),
    .cnt_b (cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // An unknown select on a valid word is illegal input.
  always @(posedge clk) begin
    if (rst_n && bus.in_valid === 1'b1 && $isunknown(bus.in_sel)) begin
      check("in_sel_known", 32'($isunknown(bus.in_sel)), 32'd0);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b0;
    bus.in_data  = '0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;

    // reset state
    #3;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_a_valid",  32'(bus.a_valid),  32'd0);
    check("rst_b_valid",  32'(bus.b_valid),  32'd0);
    check("rst_a_data",   bus.a_data, 32'h0);
    check("rst_b_data",   bus.b_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_sel = 1'b1;
    #1 check("post_rst_rdy_sel1", 32'(bus.in_ready), 32'd1);
    bus.in_sel = 1'b0;
    #1 check("post_rst_rdy_sel0", 32'(bus.in_ready), 32'd1);

    // basic routing
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b1;
    bus.in_data  = 32'hAAAAAAAA;
    @(negedge clk);
    check("route_a_valid", 32'(bus.a_valid), 32'd1);
    check("route_a_data",  bus.a_data, 32'hAAAAAAAA);
    check("route_a_bval",  32'(bus.b_valid), 32'd0);
    bus.in_sel  = 1'b0;
    bus.in_data = 32'h55555555;
    @(negedge clk);
    check("route_b_valid", 32'(bus.b_valid), 32'd1);
    check("route_b_data",  bus.b_data, 32'h55555555);
    check("route_b_aval",  32'(bus.a_valid), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("route_idle_b", 32'(bus.b_valid), 32'd0);

    // stall and fill channel A
    bus.a_ready  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b1;
    bus.in_data  = 32'hA5A5A5A5;
    @(negedge clk);
    check("fill1_a_data", bus.a_data, 32'hA5A5A5A5);
    bus.in_data = 32'hFFFFFFFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b1;
    #1 check("full_rdy_sel1", 32'(bus.in_ready), 32'd0);
    bus.in_sel = 1'b0;
    #1 check("full_rdy_sel0", 32'(bus.in_ready), 32'd1);
    check("full_a_head", bus.a_data, 32'hA5A5A5A5);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDDDDDDDD;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bypass_b_valid", 32'(bus.b_valid), 32'd1);
    check("bypass_b_data",  bus.b_data, 32'hDDDDDDDD);
    check("stall_a_head",   bus.a_data, 32'hA5A5A5A5);
    bus.a_ready = 1'b1;
    @(negedge clk);
    check("drain_a_valid2", 32'(bus.a_valid), 32'd1);
    check("drain_a_data2",  bus.a_data, 32'hFFFFFFFF);
    bus.in_sel = 1'b1;
    #1 check("recover_rdy_sel1", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("drain_a_empty", 32'(bus.a_valid), 32'd0);

    // full throughput, alternating select
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = i[0];
      bus.in_data  = 32'h10000000 + 32'(i);
      #1 check("tput_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      if (i[0]) begin
        check("tput_a_valid", 32'(bus.a_valid), 32'd1);
        check("tput_a_data",  bus.a_data, 32'h10000000 + 32'(i));
        check("tput_b_drain", 32'(bus.b_valid), 32'd0);
      end else begin
        check("tput_b_valid", 32'(bus.b_valid), 32'd1);
        check("tput_b_data",  bus.b_data, 32'h10000000 + 32'(i));
        check("tput_a_drain", 32'(bus.a_valid), 32'd0);
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("tput_end_a", 32'(bus.a_valid), 32'd0);
    check("tput_end_b", 32'(bus.b_valid), 32'd0);

    // simultaneous push and pop while holding one word
    bus.a_ready  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b1;
    bus.in_data  = 32'h00000000;
    @(negedge clk);
    check("one_a_valid", 32'(bus.a_valid), 32'd1);
    bus.a_ready = 1'b1;
    bus.in_data = 32'h12345678;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pp_a_valid", 32'(bus.a_valid), 32'd1);
    check("pp_a_data",  bus.a_data, 32'h12345678);
    #1 check("pp_rdy_sel1", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("pp_single_word", 32'(bus.a_valid), 32'd0);

    // reset with both buffers full
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_sel  = i[1];
      bus.in_data = 32'hC0DE0000 + 32'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("pre_rst_a_valid", 32'(bus.a_valid), 32'd1);
    check("pre_rst_b_valid", 32'(bus.b_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_a_valid",  32'(bus.a_valid),  32'd0);
    check("mid_rst_b_valid",  32'(bus.b_valid),  32'd0);
    check("mid_rst_a_data",   bus.a_data, 32'h0);
    check("mid_rst_b_data",   bus.b_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_sel = 1'b1;
    #1 check("rel_rdy_sel1", 32'(bus.in_ready), 32'd1);
    bus.in_sel = 1'b0;
    #1 check("rel_rdy_sel0", 32'(bus.in_ready), 32'd1);
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    @(negedge clk);
    check("no_stale_a", 32'(bus.a_valid), 32'd0);
    check("no_stale_b", 32'(bus.b_valid), 32'd0);

`ifdef DEMUX_STATS_EN
    check("cnt_a_zero", 32'(cnt_a), 32'd0);
    check("cnt_b_zero", 32'(cnt_b), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 32'h0000BEEF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("cnt_b_one", 32'(cnt_b), 32'd1);
    bus.in_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("cnt_a_three", 32'(cnt_a), 32'd3);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      bus.in_data = 32'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("cnt_a_sat",  32'(cnt_a), 32'h0000FFFF);
    check("cnt_b_hold", 32'(cnt_b), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_reg.md
# demux_reg

- Registered 1-to-2 demultiplexer with valid/ready handshakes.
- Routes each accepted input word to output A or B according to a per-word select bit.
- Buffers up to two words per output, so either channel sustains one word per cycle under back-pressure.
- Sits on the datapath wherever a 32-bit `mux` recombines two streams: it is the splitting end of that pair.

## Interface
- `WIDTH`, default 32: data word width in bits.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block accepts the input word this cycle.
- `in_data`  in  WIDTH  input word.
- `in_sel`  in  1  destination, sampled with `in_data`: 1 selects A, 0 selects B (same polarity as `mux`).
- `a_valid`  out  1  output A holds a word.
- `a_ready`  in  1  consumer A takes the word.
- `a_data`  out  WIDTH  head word of buffer A.
- `b_valid`, `b_ready`, `b_data`: same as the A ports, for channel B.
- `cnt_a`, `cnt_b`  out  16  words delivered per channel; present only with `DEMUX_STATS_EN`.

## Operation
- **Input transfer:** a transfer occurs when `in_valid && in_ready`. The word is written to buffer A if `in_sel`=1, otherwise to buffer B.
- **in_ready:**
  - Equals "selected buffer not FULL".
  - Depends combinationally on `in_sel` and the selected buffer's state only.
  - Never depends on `a_ready` or `b_ready`.
- **Buffer state machine** (one per channel): states EMPTY, ONE, FULL.
  - push only: EMPTY→ONE, ONE→FULL.
  - pop only: FULL→ONE, ONE→EMPTY.
  - push and pop together in ONE: stays ONE, and the new word becomes head.
  - push while FULL is impossible, because `in_ready`=0.
- **Output side:**
  - `x_valid` = (state != EMPTY).
  - `x_data` = oldest word in the buffer.
  - A pop occurs when `x_valid && x_ready`.
- **Ordering and isolation:**
  - Word order is preserved within each channel. No ordering is implied between A and B.
  - A stalled channel never blocks words destined for the other channel.
- **Data validity:** `x_data` is don't-care while `x_valid`=0. The implementation holds the last value.
- **Unknown select:** an X or Z on `in_sel` while `in_valid`=1 is illegal. Behaviour is unspecified, and the bench flags it.
- **Reset values** (immediately on `rst_n` low):
  - `in_ready`, `a_valid`, `b_valid` = 0.
  - `a_data`, `b_data` = 0.
  - Both buffers EMPTY.
  - `cnt_a`, `cnt_b` = 0.
- **First cycle after reset:** `in_ready`=1 for either value of `in_sel`.
- **Reset mid-operation:** all buffered words are discarded with no partial transfer. Consumers must treat any deasserted valid as empty.

## Timing
- Latency: a word accepted at edge N is presented on `x_valid`/`x_data` after edge N, i.e. one cycle.
- Throughput: with `x_ready` held 1, one word per cycle per channel. Alternating `in_sel` is sustained at one word per cycle in total.
- Back-pressure:
  - Two words fill a stalled channel.
  - `in_ready` drops in the cycle after the second push, for that select only.
  - `in_ready` recovers in the cycle after the first pop.
- A FULL buffer with a same-cycle pop still refuses a push that cycle. This removes any combinational path from ready to ready.
- `x_valid` and `x_data` are register outputs. Once asserted, `x_valid` and `x_data` stay stable until popped.

## Configuration
- `DEMUX_STATS_EN` defined:
  - `cnt_a` and `cnt_b` exist.
  - Each increments on every pop of its channel.
  - Each saturates at 16'hFFFF and is cleared only by reset.
- `DEMUX_STATS_EN` undefined:
  - The ports and counters are absent.
  - All other behaviour is identical.

## Structure
- Package `demux_pkg`:
  - `DEMUX_WIDTH` = 32.
  - `DEMUX_CNT_W` = 16.
  - Enum `buf_state_t` {BUF_EMPTY, BUF_ONE, BUF_FULL}.
- Sub-module `demux_buf` is a 2-entry buffer with push/pop, state machine, head output, and optional counter. It is instantiated twice.
- The top level contains only the select steering and `in_ready` logic.

## Test plan
- **Basic routing:** `in_sel`=1, `in_data`=32'hAAAAAAAA, both ready=1 → next cycle `a_valid`=1, `a_data`=AAAAAAAA, `b_valid`=0. Repeat with `in_sel`=0, 32'h55555555 → appears on B only.
- **Stall and fill:** `a_ready`=0; push A5A5A5A5 then FFFFFFFF to A.
  - `in_ready`=0 for `in_sel`=1 and 1 for `in_sel`=0.
  - DDDDDDDD to B passes through.
  - Release `a_ready` → A delivers A5A5A5A5 then FFFFFFFF, in order.
- **Full throughput:** 100 words alternating sel, both ready=1 → `in_ready` constant 1, every word delivered in order on its channel, each one cycle after acceptance.
- **Simultaneous push/pop in ONE:** A holds 00000000, `a_ready`=1, push 12345678 to A → state stays ONE and `a_data`=12345678 next cycle.
- **Reset mid-stream:** both buffers FULL, assert `rst_n`=0 asynchronously between edges → all outputs zero immediately. After release, `in_ready`=1 and no stale word is seen.
- **Stats (`DEMUX_STATS_EN`):** 70000 pops on A → `cnt_a`=16'hFFFF and `cnt_b` unchanged. Without the macro, the build has no `cnt_*` ports.
